// File: rtl/cmos_frame_monitor.sv
// CMOS camera frame monitor.
// Measures each complete frame from the sensor's vsync/href/de stream:
// pixel count, line count and XOR signature of the pixel data. It also
// keeps a wrapping frame counter, a frames-per-window rate and sticky
// line-length / line-count error flags. Everything runs on cmos_pclk.
module cmos_frame_monitor #(
  parameter int CLK_HZ    = 48_000_000,
  parameter int DATA_W    = 16,
  parameter int PIX_W     = 24,
  parameter int LINE_W    = 12,
  parameter int EXP_PIX   = 640,
  parameter int EXP_LINES = 480
) (
  input  logic              cmos_pclk,
  input  logic              I_rst_n,
  input  logic              I_vsync,
  input  logic              I_href,
  input  logic              I_de,
  input  logic [DATA_W-1:0] I_data,
  input  logic              I_clear,
  output logic [PIX_W-1:0]  O_frame_pixels,
  output logic [LINE_W-1:0] O_frame_lines,
  output logic [DATA_W-1:0] O_frame_xor,
  output logic              O_frame_valid,
  output logic [15:0]       O_frame_count,
  output logic [7:0]        O_fps,
  output logic              O_err_line_len,
  output logic              O_err_lines,
  output logic              O_tick
);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    IN_FRAME  = 1'b1
  } state_t;

  localparam int              WIN_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(CLK_HZ - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX   = '1;
  localparam logic [LINE_W-1:0] LINE_MAX  = '1;
  localparam logic [LINE_W-1:0] EXP_PIX_L = LINE_W'(EXP_PIX);
  localparam logic [LINE_W-1:0] EXP_LIN_L = LINE_W'(EXP_LINES);

  // Input stage 1 and the vsync/href stage 2 used for edge detection.
  logic              r_vs1, r_href1, r_de1;
  logic [DATA_W-1:0] r_data1;
  logic              r_vs2, r_href2;

  state_t            r_state;
  logic              r_rise_pend;
  logic [PIX_W-1:0]  r_pix_acc;
  logic [LINE_W-1:0] r_line_acc;
  logic [LINE_W-1:0] r_line_len;
  logic [DATA_W-1:0] r_xor_acc;

  logic [WIN_W-1:0]  r_win_cnt;
  logic [7:0]        r_win_frames;

  logic              w_vs_rise;
  logic              w_href_fall;
  logic              w_pix;
  logic              w_publish;
  logic [7:0]        w_win_next;

  assign w_vs_rise   = r_vs1 & ~r_vs2;
  assign w_href_fall = ~r_href1 & r_href2;
  // Pixels seen during vertical blanking never count.
  assign w_pix       = (r_state == IN_FRAME) & ~r_vs1 & r_de1;
  // A frame completes only if we were already synchronised to a frame start.
  assign w_publish   = r_rise_pend & (r_state == IN_FRAME);
  assign w_win_next  = (r_win_frames == 8'hFF) ? 8'hFF
                                               : r_win_frames + {7'd0, w_publish};

  // Register the camera inputs, then keep a second copy of vsync/href for edges.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs1   <= 1'b0;
      r_href1 <= 1'b0;
      r_de1   <= 1'b0;
      r_data1 <= '0;
      r_vs2   <= 1'b0;
      r_href2 <= 1'b0;
    end else begin
      r_vs1   <= I_vsync;
      r_href1 <= I_href;
      r_de1   <= I_de;
      r_data1 <= I_data;
      r_vs2   <= r_vs1;
      r_href2 <= r_href1;
    end
  end

  // Frame FSM: accumulate pixels/lines, publish statistics one clock after a vsync rise.
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state        <= WAIT_SYNC;
      r_rise_pend    <= 1'b0;
      r_pix_acc      <= '0;
      r_line_acc     <= '0;
      r_line_len     <= '0;
      r_xor_acc      <= '0;
      O_frame_pixels <= '0;
      O_frame_lines  <= '0;
      O_frame_xor    <= '0;
      O_frame_valid  <= 1'b0;
      O_frame_count  <= '0;
      O_err_line_len <= 1'b0;
      O_err_lines    <= 1'b0;
    end else if (I_clear) begin
      // Clear wins over any edge seen this cycle; published statistics hold.
      r_state        <= WAIT_SYNC;
      r_rise_pend    <= 1'b0;
      r_pix_acc      <= '0;
      r_line_acc     <= '0;
      r_line_len     <= '0;
      r_xor_acc      <= '0;
      O_frame_valid  <= 1'b0;
      O_frame_count  <= '0;
      O_err_line_len <= 1'b0;
      O_err_lines    <= 1'b0;
    end else begin
      r_rise_pend   <= w_vs_rise;
      O_frame_valid <= w_publish;
      if (r_rise_pend) begin
        // Frame boundary: optionally publish, then start a fresh frame.
        if (w_publish) begin
          O_frame_pixels <= r_pix_acc;
          O_frame_lines  <= r_line_acc;
          O_frame_xor    <= r_xor_acc;
          O_frame_count  <= O_frame_count + 16'd1;
          if ((EXP_LINES != 0) && (r_line_acc != EXP_LIN_L)) begin
            O_err_lines <= 1'b1;
          end
        end
        r_state    <= IN_FRAME;
        r_pix_acc  <= '0;
        r_line_acc <= '0;
        r_line_len <= '0;
        r_xor_acc  <= '0;
      end else if (r_state == IN_FRAME) begin
        if (w_pix) begin
          if (r_pix_acc != PIX_MAX) begin
            r_pix_acc <= r_pix_acc + 1'b1;
          end
          r_xor_acc <= r_xor_acc ^ r_data1;
        end
        if (w_href_fall && (r_line_len != '0)) begin
          if (r_line_acc != LINE_MAX) begin
            r_line_acc <= r_line_acc + 1'b1;
          end
          if ((EXP_PIX != 0) && (r_line_len != EXP_PIX_L)) begin
            O_err_line_len <= 1'b1;
          end
          r_line_len <= '0;
        end else if (w_pix && (r_line_len != LINE_MAX)) begin
          r_line_len <= r_line_len + 1'b1;
        end
      end
    end
  end

  // Measurement window: count frames per CLK_HZ cycles, a completion on the wrap cycle closes the window.
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_win_cnt    <= '0;
      r_win_frames <= '0;
      O_fps        <= '0;
      O_tick       <= 1'b0;
    end else if (I_clear) begin
      r_win_cnt    <= '0;
      r_win_frames <= '0;
      O_fps        <= '0;
    end else if (r_win_cnt == WIN_LAST) begin
      r_win_cnt    <= '0;
      r_win_frames <= '0;
      O_fps        <= w_win_next;
      O_tick       <= ~O_tick;
    end else begin
      r_win_cnt    <= r_win_cnt + 1'b1;
      r_win_frames <= w_win_next;
    end
  end

endmodule
